// File: rtl/nibble_deserializer_pkg.sv
// Shared types for the nibble deserializer: FSM state encoding and counter width.
// Optional parity frame support is selected with NIBBLE_DESER_PARITY_EN.
package nibble_deserializer_pkg;

    localparam int ND_CNT_W = 3;

    typedef enum logic [1:0] {
        ND_IDLE  = 2'd0,
        ND_SHIFT = 2'd1,
        ND_PAR   = 2'd2,
        ND_FULL  = 2'd3
    } nd_state_e;

endpackage

// File: rtl/nibble_deserializer_if.sv
// Bit-strobe input and word handshake bundle of the nibble deserializer.
// Optional parity frame support is selected with NIBBLE_DESER_PARITY_EN.
interface nibble_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic             SI;
    logic             START;
    logic             RDY;
    logic [WIDTH-1:0] O;
    logic             VALID;
    logic             OVF;
    logic             PERR;

    modport master (
        output EN, SI, START, RDY,
        input  O, VALID, OVF, PERR
    );

    modport slave (
        input  EN, SI, START, RDY,
        output O, VALID, OVF, PERR
    );
endinterface

// File: rtl/nibble_deserializer_bit_counter.sv
// Frame bit counter for the nibble deserializer, clocked on the falling edge of C.
// Optional parity frame support is selected with NIBBLE_DESER_PARITY_EN.
module deser_bit_counter
    import nibble_deserializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic C,
    input  logic CLR,
    input  logic i_load,
    input  logic i_inc,
    output logic o_last
);
    logic [ND_CNT_W-1:0] r_cnt;

    always_ff @(negedge C) begin
        if (CLR) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= ND_CNT_W'(1);
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Flag the bit before WIDTH so WIDTH=8 still fits a 3-bit count.
    assign o_last = (r_cnt == ND_CNT_W'(WIDTH - 1));
endmodule

// File: rtl/nibble_deserializer.sv
// LSB-first serial-to-word deserializer with VALID/RDY output and sticky overrun.
// Define NIBBLE_DESER_PARITY_EN to append an even-parity bit to each frame.
module nibble_deserializer
    import nibble_deserializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic C,
    input  logic CLR,
    nibble_deserializer_if.slave bus
);
`ifdef NIBBLE_DESER_PARITY_EN
    localparam nd_state_e ND_DONE = ND_PAR;
`else
    localparam nd_state_e ND_DONE = ND_FULL;
`endif

    nd_state_e        r_state;
    nd_state_e        w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_ovf;
    logic             w_start;
    logic             w_bit;
    logic             w_last;
    logic             w_load;
    logic             w_shift;
    logic             w_ovf_set;
    logic             w_valid;

    assign w_start = bus.EN & bus.START;
    assign w_bit   = bus.EN & ~bus.START;

    deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .C      (C),
        .CLR    (CLR),
        .i_load (w_load),
        .i_inc  (w_shift),
        .o_last (w_last)
    );

    always_ff @(negedge C) begin
        if (CLR) r_state <= ND_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ND_IDLE:  if (w_start) w_next = ND_SHIFT;
            ND_SHIFT: if (w_bit && w_last) w_next = ND_DONE;
            ND_PAR:   if (bus.EN) w_next = ND_FULL;
            ND_FULL:  if (bus.RDY) w_next = w_start ? ND_SHIFT : ND_IDLE;
            default:  w_next = ND_IDLE;
        endcase
    end

`ifdef NIBBLE_DESER_PARITY_EN
    logic w_par_ld;
`endif

    always_comb begin
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_ovf_set = 1'b0;
        w_valid   = 1'b0;
`ifdef NIBBLE_DESER_PARITY_EN
        w_par_ld  = 1'b0;
`endif
        unique case (r_state)
            ND_IDLE: w_load = w_start;
            ND_SHIFT: begin
                w_load  = w_start;
                w_shift = w_bit;
            end
            ND_PAR: begin
`ifdef NIBBLE_DESER_PARITY_EN
                w_par_ld = bus.EN;
`endif
            end
            ND_FULL: begin
                w_valid   = 1'b1;
                w_load    = bus.RDY & w_start;
                w_ovf_set = ~bus.RDY & w_start;
            end
            default: ;
        endcase
    end

    always_ff @(negedge C) begin
        if (CLR) begin
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_load)
                r_data <= {bus.SI, {(WIDTH-1){1'b0}}};
            else if (w_shift)
                r_data <= {bus.SI, r_data[WIDTH-1:1]};
            if (w_ovf_set)
                r_ovf <= 1'b1;
        end
    end

`ifdef NIBBLE_DESER_PARITY_EN
    logic r_perr;

    always_ff @(negedge C) begin
        if (CLR)           r_perr <= 1'b0;
        else if (w_load)   r_perr <= 1'b0;
        else if (w_par_ld) r_perr <= ^{r_data, bus.SI};
    end

    assign bus.PERR = r_perr;
`else
    assign bus.PERR = 1'b0;
`endif

    assign bus.O     = r_data;
    assign bus.VALID = w_valid;
    assign bus.OVF   = r_ovf;
endmodule

// File: tb/tb_nibble_deserializer.sv
// Scoreboard bench for nibble_deserializer (WIDTH=4, C period 14).
// Parity cases are exercised when NIBBLE_DESER_PARITY_EN is defined.
module tb_nibble_deserializer;
    localparam int W = 4;

    logic C   = 1'b0;
    logic CLR = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [W-1:0] sb_q[$];

    nibble_deserializer_if #(.WIDTH(W)) bus();

    nibble_deserializer #(.WIDTH(W)) dut (
        .C   (C),
        .CLR (CLR),
        .bus (bus)
    );

    always #7 C = ~C;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Inputs change 3 time units after a falling edge and apply at the next one.
    task automatic step(input logic en, input logic st,
                        input logic si, input logic rdy);
        @(negedge C);
        #3;
        bus.EN    = en;
        bus.START = st;
        bus.SI    = si;
        bus.RDY   = rdy;
    endtask

    task automatic do_reset;
        @(negedge C);
        #3;
        CLR       = 1'b1;
        bus.EN    = 1'b0;
        bus.START = 1'b0;
        bus.RDY   = 1'b0;
        @(negedge C);
        #3;
        CLR = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic rdy);
        for (int i = 0; i < W; i++)
            step(1'b1, (i == 0), w[i], rdy);
`ifdef NIBBLE_DESER_PARITY_EN
        step(1'b1, 1'b0, ^w, rdy);
`endif
        sb_q.push_back(w);
    endtask

    task automatic ack;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // A handshake completes at the next falling edge: compare the word now.
    always @(posedge C) begin
        if (bus.VALID === 1'b1 && bus.RDY === 1'b1 && CLR === 1'b0) begin
            check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0)
                check("sb_word", 32'(bus.O), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        bus.EN    = 1'b0;
        bus.START = 1'b0;
        bus.SI    = 1'b0;
        bus.RDY   = 1'b0;

        do_reset;
        check("rst_o",     32'(bus.O), 32'd0);
        check("rst_valid", 32'(bus.VALID), 32'd0);
        check("rst_ovf",   32'(bus.OVF), 32'd0);
        check("rst_perr",  32'(bus.PERR), 32'd0);

        // basic frame
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("valid_early", 32'(bus.VALID), 32'd0);
`ifdef NIBBLE_DESER_PARITY_EN
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("valid_b4_par", 32'(bus.VALID), 32'd0);
`endif
        sb_q.push_back(4'b1101);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_valid", 32'(bus.VALID), 32'd1);
        check("t1_o",     32'(bus.O), 32'h d);
        check("t1_perr",  32'(bus.PERR), 32'd0);
        ack;
        check("t1_ack", 32'(bus.VALID), 32'd0);

        // overrun
        send_frame(4'b1101, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_valid", 32'(bus.VALID), 32'd1);
        check("t2_ovf0",  32'(bus.OVF), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_ovf",  32'(bus.OVF), 32'd1);
        check("t2_o",    32'(bus.O), 32'h d);
        check("t2_hold", 32'(bus.VALID), 32'd1);
        ack;
        check("t2_ack",    32'(bus.VALID), 32'd0);
        check("t2_sticky", 32'(bus.OVF), 32'd1);
        do_reset;
        check("t2_clr", 32'(bus.OVF), 32'd0);

        // back-to-back with RDY high
        send_frame(4'b1101, 1'b1);
        send_frame(4'b0110, 1'b1);
        ack;
        check("t3_valid", 32'(bus.VALID), 32'd0);
        check("t3_ovf",   32'(bus.OVF), 32'd0);
        check("t3_sb",    32'(sb_q.size()), 32'd0);

        // restart and gaps
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef NIBBLE_DESER_PARITY_EN
        step(1'b1, 1'b0, 1'b1, 1'b0);
`endif
        sb_q.push_back(4'b0100);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_valid", 32'(bus.VALID), 32'd1);
        check("t4_o",     32'(bus.O), 32'h4);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_full_ign", 32'(bus.O), 32'h4);
        check("t4_full_ovf", 32'(bus.OVF), 32'd0);
        ack;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_idle_ign", 32'(bus.VALID), 32'd0);

        // reset mid-frame
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset;
        check("t5_o",     32'(bus.O), 32'd0);
        check("t5_valid", 32'(bus.VALID), 32'd0);
        check("t5_ovf",   32'(bus.OVF), 32'd0);
        send_frame(4'b0101, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_valid2", 32'(bus.VALID), 32'd1);
        check("t5_o2",     32'(bus.O), 32'h5);
        check("t5_perr",   32'(bus.PERR), 32'd0);
        ack;

`ifdef NIBBLE_DESER_PARITY_EN
        // bad parity bit
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(4'b1101);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_valid", 32'(bus.VALID), 32'd1);
        check("t6_perr",  32'(bus.PERR), 32'd1);
        ack;
        send_frame(4'b1101, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_perr_ok", 32'(bus.PERR), 32'd0);
        ack;
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
